// File: rtl/xyolo_read_sched.sv
// -----------------------------------------------------------------------------
// xyolo_read_sched
//   Tile scheduler for the YOLO weight/bias read unit. The CPU programs a base
//   address, a stride and a tile count, then starts a sequence. For every tile
//   the scheduler writes the read unit's EXT_ADDR config register and pulses
//   its run. Tile k+1's address is written while tile k is still in flight,
//   because the read unit copies its configuration into shadow registers on
//   run.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   valid/addr/wdata/ CPU register writes (0=BASE 1=STRIDE 2=NTILES 3=CTRL);
//   wstrb             CTRL bit0 = start, bit1 = abort
//   cfg_*             config write port towards the read unit
//   yread_run         one-cycle run pulse to the read unit
//   yread_done        level done from the read unit
//   busy              sequence in progress
//   tiles_done        tiles completed since the last start
//   sched_done        one-cycle pulse when a sequence ends (completed or aborted)
// -----------------------------------------------------------------------------
module xyolo_read_sched #(
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned CFG_ADDR_W    = 4,
   parameter int unsigned EXT_ADDR_CODE = 0,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned DONE_LAT      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic [1:0]            addr,
   input  logic [ADDR_W-1:0]     wdata,
   input  logic                  wstrb,
   output logic                  cfg_valid,
   output logic [CFG_ADDR_W-1:0] cfg_addr,
   output logic [ADDR_W-1:0]     cfg_wdata,
   output logic                  cfg_wstrb,
   output logic                  yread_run,
   input  logic                  yread_done,
   output logic                  busy,
   output logic [CNT_W-1:0]      tiles_done,
   output logic                  sched_done
);

   localparam int unsigned SET_W = $clog2(DONE_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CFG, S_RUN, S_PRECFG, S_SETTLE, S_WAIT, S_FINISH
   } state_t;

   state_t state, state_nxt;

   // CPU-visible registers
   logic [ADDR_W-1:0] base, stride;
   logic [CNT_W-1:0]  ntiles;

   // Values latched at start, so CPU writes during a sequence do not disturb it
   logic [ADDR_W-1:0] stride_lat, cur_addr;
   logic [CNT_W-1:0]  ntiles_lat, issued;
   logic [SET_W-1:0]  settle;
   logic              abort_flag;

   logic              wr, start_req, abort_req, abort_pend;
   logic [CNT_W-1:0]  issued_inc, tiles_inc;

   assign wr         = valid & wstrb;
   assign start_req  = wr && (addr == 2'd3) && wdata[0] && (state == S_IDLE);
   assign abort_req  = wr && (addr == 2'd3) && wdata[1] && (state != S_IDLE);
   // An abort written in this very cycle already counts, so RUN can skip PRECFG
   assign abort_pend = abort_flag | abort_req;
   assign issued_inc = issued + CNT_W'(1);
   assign tiles_inc  = tiles_done + CNT_W'(1);

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (start_req) state_nxt = (ntiles == '0) ? S_FINISH : S_CFG;
         S_CFG:    state_nxt = S_RUN;
         S_RUN:    state_nxt = (issued_inc < ntiles_lat && !abort_pend) ? S_PRECFG : S_SETTLE;
         // The settle counter already counts down in PRECFG; with DONE_LAT = 1
         // it expires here and WAIT follows directly.
         S_PRECFG: state_nxt = (settle <= SET_W'(1)) ? S_WAIT : S_SETTLE;
         S_SETTLE: if (settle <= SET_W'(1)) state_nxt = S_WAIT;
         S_WAIT:   if (yread_done)
                      state_nxt = (abort_pend || tiles_inc == ntiles_lat) ? S_FINISH : S_RUN;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the state alone, so reset clears them at once
   assign cfg_valid  = (state == S_CFG) || (state == S_PRECFG);
   assign cfg_wstrb  = cfg_valid;
   assign cfg_addr   = cfg_valid ? CFG_ADDR_W'(EXT_ADDR_CODE) : '0;
   assign cfg_wdata  = cfg_valid ? cur_addr : '0;
   assign yread_run  = (state == S_RUN);
   assign sched_done = (state == S_FINISH);
   assign busy       = (state != S_IDLE);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         base       <= '0;
         stride     <= '0;
         ntiles     <= '0;
         stride_lat <= '0;
         cur_addr   <= '0;
         ntiles_lat <= '0;
         issued     <= '0;
         tiles_done <= '0;
         settle     <= '0;
         abort_flag <= 1'b0;
      end else begin
         state <= state_nxt;

         if (wr) begin
            unique case (addr)
               2'd0:    base   <= wdata;
               2'd1:    stride <= wdata;
               2'd2:    ntiles <= wdata[CNT_W-1:0];
               default: ;
            endcase
         end

         if (state == S_FINISH) abort_flag <= 1'b0;
         else if (abort_req)    abort_flag <= 1'b1;

         unique case (state)
            S_IDLE: if (start_req) begin
               cur_addr   <= base;
               stride_lat <= stride;
               ntiles_lat <= ntiles;
               issued     <= '0;
               tiles_done <= '0;
            end
            S_CFG:    cur_addr <= cur_addr + stride_lat;
            S_RUN: begin
               issued <= issued_inc;
               settle <= SET_W'(DONE_LAT);
            end
            S_PRECFG: begin
               cur_addr <= cur_addr + stride_lat;
               settle   <= settle - SET_W'(1);
            end
            S_SETTLE: settle <= settle - SET_W'(1);
            S_WAIT:   if (yread_done) tiles_done <= tiles_inc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_xyolo_read_sched.sv
// -----------------------------------------------------------------------------
// tb_xyolo_read_sched
//   Directed and randomized sequences for xyolo_read_sched. A negedge process
//   logs every config write, run pulse and sched_done and plays the read unit,
//   returning done a fixed latency after each run (or holding it high). The
//   expected address list, run times and counts come from the tile arithmetic:
//   tile k uses base + k*stride, runs are (latency + 1) cycles apart, the first
//   run is two cycles after the start write.
// -----------------------------------------------------------------------------
module tb_xyolo_read_sched;

   localparam int unsigned ADDR_W        = 32;
   localparam int unsigned CFG_ADDR_W    = 4;
   localparam int unsigned EXT_ADDR_CODE = 5;
   localparam int unsigned CNT_W         = 16;
   localparam int unsigned DONE_LAT      = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  valid;
   logic [1:0]            addr;
   logic [ADDR_W-1:0]     wdata;
   logic                  wstrb;
   logic                  cfg_valid;
   logic [CFG_ADDR_W-1:0] cfg_addr;
   logic [ADDR_W-1:0]     cfg_wdata;
   logic                  cfg_wstrb;
   logic                  yread_run;
   logic                  yread_done;
   logic                  busy;
   logic [CNT_W-1:0]      tiles_done;
   logic                  sched_done;

   xyolo_read_sched #(
      .ADDR_W(ADDR_W), .CFG_ADDR_W(CFG_ADDR_W), .EXT_ADDR_CODE(EXT_ADDR_CODE),
      .CNT_W(CNT_W), .DONE_LAT(DONE_LAT)
   ) dut (
      .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_wstrb(cfg_wstrb), .yread_run(yread_run), .yread_done(yread_done),
      .busy(busy), .tiles_done(tiles_done), .sched_done(sched_done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   logic [31:0] cfg_log[$];
   int unsigned run_log[$];
   int unsigned sdone_log[$];
   int unsigned done_at[$];
   int          proto_err  = 0;
   bit          done_const = 1'b0;
   int unsigned lat        = 10;
   int unsigned wr_cyc     = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Monitor plus read-unit model, both on the falling edge
   initial begin
      yread_done = 1'b0;
      forever begin
         @(negedge clk);
         if (cfg_valid) begin
            cfg_log.push_back(cfg_wdata);
            if (cfg_addr !== CFG_ADDR_W'(EXT_ADDR_CODE)) proto_err++;
         end else if (cfg_addr !== '0) proto_err++;
         if (cfg_wstrb !== cfg_valid) proto_err++;
         if (cfg_valid && yread_run) proto_err++;
         if (yread_run) begin
            run_log.push_back(cyc);
            done_at.push_back(cyc + lat);
         end
         if (sched_done) sdone_log.push_back(cyc);
         if (done_const) yread_done = 1'b1;
         else if (done_at.size() > 0 && done_at[0] == cyc) begin
            yread_done = 1'b1;
            void'(done_at.pop_front());
         end else yread_done = 1'b0;
      end
   end

   task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      valid = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
      wr_cyc = cyc;
      @(posedge clk);
      #1;
      valid = 1'b0; wstrb = 1'b0;
   endtask

   task automatic clear_logs();
      cfg_log.delete(); run_log.delete(); sdone_log.delete(); done_at.delete();
   endtask

   // One complete sequence against the tile-arithmetic model
   task automatic run_seq(input string name, input logic [31:0] base, input logic [31:0] stride,
                          input int n, input int unsigned l, input bit cst, input bit do_abort);
      int unsigned t0, gap, n_run, n_cfg;
      int          pe0;
      logic [31:0] a;
      done_const = cst;
      lat        = l;
      clear_logs();
      pe0 = proto_err;
      cpu_write(2'd0, base);
      cpu_write(2'd1, stride);
      cpu_write(2'd2, 32'(n));
      cpu_write(2'd3, 32'h1);
      t0 = wr_cyc;
      if (do_abort) begin
         repeat (2) @(posedge clk);
         cpu_write(2'd3, 32'h2);
      end
      for (int i = 0; i < 3000 && sdone_log.size() == 0; i++) @(negedge clk);
      check({name, " sched_done seen"}, 64'(sdone_log.size() != 0), 64'd1);
      repeat (3) @(negedge clk);

      gap   = cst ? DONE_LAT + 2 : l + 1;
      n_run = do_abort ? 1 : n;
      n_cfg = do_abort ? ((n < 2) ? n : 2) : n;

      check({name, " run count"}, 64'(run_log.size()), 64'(n_run));
      check({name, " cfg count"}, 64'(cfg_log.size()), 64'(n_cfg));
      for (int i = 0; i < n_cfg && i < cfg_log.size(); i++) begin
         a = base + 32'(i) * stride;
         check($sformatf("%s cfg_wdata[%0d]", name, i), 64'(cfg_log[i]), 64'(a));
      end
      for (int i = 0; i < n_run && i < run_log.size(); i++)
         check($sformatf("%s run time[%0d]", name, i), 64'(run_log[i] - t0),
               64'(2 + i * gap));
      check({name, " sched_done pulses"}, 64'(sdone_log.size()), 64'd1);
      if (n > 0 && sdone_log.size() > 0)
         check({name, " sched_done time"}, 64'(sdone_log[0] - t0), 64'(2 + n_run * gap));
      check({name, " tiles_done"}, 64'(tiles_done), 64'(n_run));
      check({name, " busy after end"}, 64'(busy), 64'd0);
      check({name, " cfg/run protocol"}, 64'(proto_err - pe0), 64'd0);
   endtask

   initial begin
      int unsigned t0;
      rst = 1'b1; valid = 1'b0; wstrb = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      check("reset busy",       64'(busy),       64'd0);
      check("reset cfg_valid",  64'(cfg_valid),  64'd0);
      check("reset yread_run",  64'(yread_run),  64'd0);
      check("reset tiles_done", 64'(tiles_done), 64'd0);
      check("reset sched_done", 64'(sched_done), 64'd0);
      rst = 1'b0;

      run_seq("basic",  32'h1000,     32'h200, 3, 10, 1'b0, 1'b0);
      run_seq("zero",   32'h1000,     32'h200, 0, 10, 1'b0, 1'b0);
      run_seq("const",  32'h2000,     32'h40,  2, 10, 1'b1, 1'b0);
      run_seq("abort",  32'h3000,     32'h100, 5, 10, 1'b0, 1'b1);
      run_seq("wrap",   32'hFFFFFF00, 32'h100, 2, 10, 1'b0, 1'b0);

      // Reset while waiting for done, then a fresh single-tile sequence
      done_const = 1'b0; lat = 10;
      clear_logs();
      cpu_write(2'd0, 32'h1000);
      cpu_write(2'd1, 32'h200);
      cpu_write(2'd2, 32'd3);
      cpu_write(2'd3, 32'h1);
      t0 = wr_cyc;
      while (cyc < t0 + 8) @(negedge clk);
      check("busy before rst", 64'(busy), 64'd1);
      #1 rst = 1'b1;
      #1;
      check("rst busy",       64'(busy),       64'd0);
      check("rst cfg_valid",  64'(cfg_valid),  64'd0);
      check("rst cfg_wdata",  64'(cfg_wdata),  64'd0);
      check("rst yread_run",  64'(yread_run),  64'd0);
      check("rst tiles_done", 64'(tiles_done), 64'd0);
      check("rst sched_done", 64'(sched_done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_log.delete();
      repeat (20) @(negedge clk);
      check("post-rst no run",        64'(run_log.size()), 64'd0);
      check("post-rst tiles_done",    64'(tiles_done),     64'd0);
      run_seq("after_rst", 32'h1000, 32'h200, 1, 10, 1'b0, 1'b0);

      for (int k = 0; k < 6; k++)
         run_seq($sformatf("rand%0d", k), $urandom, $urandom, int'($urandom_range(1, 6)),
                 $urandom_range(DONE_LAT + 1, DONE_LAT + 8), 1'b0, 1'b0);
      run_seq("rand_const", $urandom, $urandom, int'($urandom_range(1, 5)), 10, 1'b1, 1'b0);
      run_seq("rand_abort", $urandom, $urandom, int'($urandom_range(2, 6)),
              $urandom_range(DONE_LAT + 1, DONE_LAT + 8), 1'b0, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
